adder_scheduler: RTL and testbench

Round-robin scheduler that shares one registered adder datapath (a, b, valid in; c out; 4-bit operands, 7-bit result) among NUM_REQ requesters. It accepts one operand pair at a time over a per-requester valid/ready handshake and issues it to the adder as a single-cycle valid pulse. It waits the adder latency, captures c, and returns the result tagged with the requester index over a valid/ready response port. It sits between the client blocks and the adder instance.

---
 rtl/adder_scheduler_pkg.sv | 14 +
 rtl/adder_scheduler_rr_arbiter.sv | 42 ++++
 rtl/adder_scheduler.sv | 124 ++++++++++++
 tb/tb_adder_scheduler.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_scheduler_pkg.sv
// Shared types and default widths for the adder scheduler and its arbiter.
package adder_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int unsigned DEFAULT_A_W = 4;
  localparam int unsigned DEFAULT_C_W = 7;

endpackage

// File: rtl/adder_scheduler_rr_arbiter.sv
// Combinational round-robin pick: lowest requester at or above ptr, else lowest overall.
module rr_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         grant_valid
);

  logic [N-1:0] masked;
  logic         found;

  always_comb begin
    masked      = '0;
    grant       = '0;
    grant_idx   = '0;
    found       = 1'b0;
    for (int i = 0; i < N; i++) begin
      masked[i] = req[i] && (W'(i) >= ptr);
    end
    // Masked pass covers ptr..N-1; the unmasked pass supplies the wrap to 0..ptr-1.
    for (int i = 0; i < N; i++) begin
      if (masked[i] && !found) begin
        grant[i]  = 1'b1;
        grant_idx = W'(i);
        found     = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (req[i] && !found) begin
        grant[i]  = 1'b1;
        grant_idx = W'(i);
        found     = 1'b1;
      end
    end
    grant_valid = found;
  end

endmodule

// File: rtl/adder_scheduler.sv
// Round-robin scheduler sharing one registered adder among NUM_REQ requesters,
// returning each sum tagged with the owning requester index.
module adder_scheduler
  import adder_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned A_W     = DEFAULT_A_W,
  parameter int unsigned C_W     = DEFAULT_C_W,
  parameter int unsigned ADD_LAT = 1,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*A_W-1:0] req_b,
  output logic [A_W-1:0]         add_a,
  output logic [A_W-1:0]         add_b,
  output logic                   add_valid,
  input  logic [C_W-1:0]         add_c,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [C_W-1:0]         rsp_c,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   busy
);

  localparam int unsigned CNT_W = $clog2(ADD_LAT + 1);

  if (C_W < A_W + 1 || ADD_LAT < 1 || NUM_REQ < 2 || NUM_REQ > 16) begin : g_param_check
    $error("adder_scheduler: illegal parameter combination");
  end

  state_e             state;
  logic [ID_W-1:0]    ptr;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_valid;
  logic [ID_W-1:0]    next_ptr;
  logic [A_W-1:0]     sel_a;
  logic [A_W-1:0]     sel_b;

  rr_arbiter #(
    .N (NUM_REQ),
    .W (ID_W)
  ) u_arb (
    .req         (req_valid),
    .ptr         (ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Grant is offered only in IDLE and never while reset is being applied.
  assign req_ready = (state == IDLE && reset) ? grant : '0;
  assign next_ptr  = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*A_W +: A_W];
        sel_b = req_b[i*A_W +: A_W];
      end
    end
  end

  // add_a/add_b double as the operand registers: loaded on accept, cleared after ISSUE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      add_a     <= '0;
      add_b     <= '0;
      add_valid <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_c     <= '0;
      rsp_id    <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            add_a     <= sel_a;
            add_b     <= sel_b;
            add_valid <= 1'b1;
            rsp_id    <= grant_idx;
            ptr       <= next_ptr;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          add_valid <= 1'b0;
          add_a     <= '0;
          add_b     <= '0;
          cnt       <= CNT_W'(ADD_LAT);
          state     <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            rsp_c     <= add_c;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_scheduler.sv
// Randomized self-checking bench for adder_scheduler with a behavioural arbitration model
// and a bench-side adder; a second instance covers ADD_LAT=3.
module tb_adder_scheduler;

  localparam int unsigned N    = 4;
  localparam int unsigned A_W  = 4;
  localparam int unsigned C_W  = 7;
  localparam int unsigned ID_W = 2;
  localparam int unsigned AB_W = N * A_W;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]     req_valid, req_ready;
  logic [AB_W-1:0]  req_a, req_b;
  logic [A_W-1:0]   add_a, add_b;
  logic             add_valid;
  logic [C_W-1:0]   add_c;
  logic             rsp_valid, rsp_ready;
  logic [C_W-1:0]   rsp_c;
  logic [ID_W-1:0]  rsp_id;
  logic             busy;

  logic [N-1:0]     l3_req_valid, l3_req_ready;
  logic [AB_W-1:0]  l3_req_a, l3_req_b;
  logic [A_W-1:0]   l3_add_a, l3_add_b;
  logic             l3_add_valid;
  logic [C_W-1:0]   l3_add_c;
  logic             l3_rsp_valid, l3_rsp_ready;
  logic [C_W-1:0]   l3_rsp_c;
  logic [ID_W-1:0]  l3_rsp_id;
  logic             l3_busy;

  int checks = 0;
  int errors = 0;
  int mptr   = 0;

  adder_scheduler #(.NUM_REQ(N), .A_W(A_W), .C_W(C_W), .ADD_LAT(1), .ID_W(ID_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .add_a(add_a), .add_b(add_b), .add_valid(add_valid),
    .add_c(add_c), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c),
    .rsp_id(rsp_id), .busy(busy)
  );

  adder_scheduler #(.NUM_REQ(N), .A_W(A_W), .C_W(C_W), .ADD_LAT(3), .ID_W(ID_W)) dut_lat3 (
    .clk(clk), .reset(reset), .req_valid(l3_req_valid), .req_ready(l3_req_ready),
    .req_a(l3_req_a), .req_b(l3_req_b), .add_a(l3_add_a), .add_b(l3_add_b),
    .add_valid(l3_add_valid), .add_c(l3_add_c), .rsp_valid(l3_rsp_valid),
    .rsp_ready(l3_rsp_ready), .rsp_c(l3_rsp_c), .rsp_id(l3_rsp_id), .busy(l3_busy)
  );

  // Bench adders: the sum is visible exactly ADD_LAT cycles after the valid edge, junk otherwise.
  logic             l3_v1, l3_v2;
  logic [C_W-1:0]   l3_s1, l3_s2;
  always @(posedge clk) begin
    add_c    <= add_valid ? C_W'(add_a) + C_W'(add_b) : C_W'($urandom);
    l3_v1    <= l3_add_valid;
    l3_s1    <= C_W'(l3_add_a) + C_W'(l3_add_b);
    l3_v2    <= l3_v1;
    l3_s2    <= l3_s1;
    l3_add_c <= l3_v2 ? l3_s2 : C_W'($urandom);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clk);
    reset     = 1'b0;
    req_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    mptr  = 0;
  endtask

  // One operation on the ADD_LAT=1 instance, starting at a negedge with the DUT idle.
  task automatic do_op(input logic [N-1:0] mask, input logic [AB_W-1:0] av,
                       input logic [AB_W-1:0] bv, input int stall);
    int g;
    int exp_sum;
    logic [N-1:0] exp_oh;
    logic [A_W-1:0] ag, bg;
    req_valid = mask;
    req_a     = av;
    req_b     = bv;
    rsp_ready = 1'b0;
    g = -1;
    for (int k = 0; k < int'(N); k++) begin
      int idx;
      idx = (mptr + k) % N;
      if (g < 0 && mask[idx]) g = idx;
    end
    exp_oh = '0;
    if (g >= 0) exp_oh[g] = 1'b1;
    #1;
    checks++;
    if (req_ready !== exp_oh) begin
      errors++;
      $display("FAIL grant: req_ready=%b want %b (mask %b ptr %0d)", req_ready, exp_oh, mask, mptr);
    end
    @(negedge clk);
    if (g < 0) begin
      checks++;
      if (busy !== 1'b0 || add_valid !== 1'b0) begin
        errors++;
        $display("FAIL no_request: busy=%b add_valid=%b want 0 0", busy, add_valid);
      end
      return;
    end
    mptr    = (g + 1) % N;
    ag      = av[g*A_W +: A_W];
    bg      = bv[g*A_W +: A_W];
    exp_sum = int'(ag) + int'(bg);
    checks++;
    if (add_valid !== 1'b1 || add_a !== ag || add_b !== bg || busy !== 1'b1 || req_ready !== '0) begin
      errors++;
      $display("FAIL issue: add_valid=%b a=%0d b=%0d busy=%b req_ready=%b want 1 %0d %0d 1 0",
               add_valid, add_a, add_b, busy, req_ready, ag, bg);
    end
    @(negedge clk);
    checks++;
    if (add_valid !== 1'b0 || add_a !== '0 || add_b !== '0 || rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wait: add_valid=%b a=%0d b=%0d rsp_valid=%b busy=%b want 0 0 0 0 1",
               add_valid, add_a, add_b, rsp_valid, busy);
    end
    @(negedge clk);
    for (int s = 0; s <= stall; s++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_c !== C_W'(exp_sum) || rsp_id !== ID_W'(g) ||
          req_ready !== '0 || add_valid !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL resp[%0d]: rsp_valid=%b c=%0d id=%0d req_ready=%b add_valid=%b busy=%b want 1 %0d %0d 0 0 1",
                 s, rsp_valid, rsp_c, rsp_id, req_ready, add_valid, busy, exp_sum, g);
      end
      if (s == stall) rsp_ready = 1'b1;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL back_to_idle: rsp_valid=%b busy=%b want 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_reset();
    req_valid    = '1;
    l3_req_valid = '1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== '0 || l3_req_ready !== '0 || add_valid !== 1'b0 || add_a !== '0 ||
        add_b !== '0 || rsp_valid !== 1'b0 || rsp_c !== '0 || rsp_id !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: req_ready=%b add_valid=%b a=%0d b=%0d rsp_valid=%b c=%0d id=%0d busy=%b want all 0",
               req_ready, add_valid, add_a, add_b, rsp_valid, rsp_c, rsp_id, busy);
    end
    req_valid    = '0;
    l3_req_valid = '0;
    reset        = 1'b1;
    mptr         = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || l3_busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%b rsp_valid=%b l3_busy=%b want 0 0 0", busy, rsp_valid, l3_busy);
    end
  endtask

  task automatic test_single();
    do_op(4'b0001, AB_W'(3), AB_W'(5), 0);
  endtask

  task automatic test_round_robin();
    logic [AB_W-1:0] av, bv;
    apply_reset();
    for (int i = 0; i < int'(N); i++) begin
      av[i*A_W +: A_W] = A_W'(i);
      bv[i*A_W +: A_W] = A_W'(i + 1);
    end
    for (int r = 0; r < 5; r++) do_op('1, av, bv, 0);
  endtask

  task automatic test_back_pressure();
    do_op('1, '1, '1, 10);
  endtask

  task automatic test_pointer_wrap();
    apply_reset();
    do_op(4'b0100, AB_W'($urandom), AB_W'($urandom), 0);
    do_op(4'b0101, AB_W'($urandom), AB_W'($urandom), 0);
    do_op(4'b0101, AB_W'($urandom), AB_W'($urandom), 0);
  endtask

  task automatic test_reset_mid_wait();
    req_valid = 4'b0010;
    req_a     = AB_W'($urandom);
    req_b     = AB_W'($urandom);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== '0 || add_valid !== 1'b0 || add_a !== '0 || add_b !== '0 ||
        rsp_valid !== 1'b0 || rsp_c !== '0 || rsp_id !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_wait: add_valid=%b a=%0d b=%0d rsp_valid=%b c=%0d id=%0d busy=%b want all 0",
               add_valid, add_a, add_b, rsp_valid, rsp_c, rsp_id, busy);
    end
    reset = 1'b1;
    mptr  = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL aborted_op_response[%0d]: rsp_valid=%b busy=%b want 0 0", i, rsp_valid, busy);
      end
    end
    do_op('1, AB_W'($urandom), AB_W'($urandom), 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      do_op(N'($urandom_range(0, 15)), AB_W'($urandom), AB_W'($urandom), $urandom_range(0, 3));
    end
  endtask

  task automatic test_add_lat3();
    l3_rsp_ready = 1'b0;
    l3_req_valid = 4'b0001;
    l3_req_a     = AB_W'(9);
    l3_req_b     = AB_W'(7);
    #1;
    checks++;
    if (l3_req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL lat3_grant: req_ready=%b want 0001", l3_req_ready);
    end
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      l3_req_valid = '0;
      checks++;
      if (l3_add_valid !== (c == 1) || l3_rsp_valid !== (c == 5) || l3_busy !== 1'b1) begin
        errors++;
        $display("FAIL lat3_cycle%0d: add_valid=%b rsp_valid=%b busy=%b want %b %b 1",
                 c, l3_add_valid, l3_rsp_valid, l3_busy, c == 1, c == 5);
      end
    end
    checks++;
    if (l3_rsp_c !== C_W'(16) || l3_rsp_id !== '0) begin
      errors++;
      $display("FAIL lat3_result: c=%0d id=%0d want 16 0", l3_rsp_c, l3_rsp_id);
    end
    l3_rsp_ready = 1'b1;
    @(negedge clk);
    l3_rsp_ready = 1'b0;
    checks++;
    if (l3_rsp_valid !== 1'b0 || l3_busy !== 1'b0) begin
      errors++;
      $display("FAIL lat3_idle: rsp_valid=%b busy=%b want 0 0", l3_rsp_valid, l3_busy);
    end
  endtask

  initial begin
    req_valid    = '0;
    req_a        = '0;
    req_b        = '0;
    rsp_ready    = 1'b0;
    l3_req_valid = '0;
    l3_req_a     = '0;
    l3_req_b     = '0;
    l3_rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_pointer_wrap();
    test_reset_mid_wait();
    test_random();
    test_add_lat3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
